// File: rtl/vga_term_writer.sv
// vga_term_writer: turns a byte stream into vga_top text-buffer write beats with an 80x30 wrapping cursor.
// Define AUTO_CLEAR_EN to run a full-screen clear right after reset.
module vga_term_writer #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int N_COL            = 80,
  parameter int N_ROW            = 30,
  parameter int WR_HOLD          = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    char_i,
  input  logic                          char_valid_i,
  output logic                          char_ready_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [3:0]                    axil_wstrb_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic                          axil_wready_o,
  output logic [6:0]                    cursor_col_o,
  output logic [4:0]                    cursor_row_o,
  output logic                          busy_o
);
  localparam int HW        = $clog2(WR_HOLD + 1);
  localparam int WW        = $clog2(N_COL * N_ROW / 4);
  localparam int LINE_LAST = N_COL / 4 - 1;
  localparam int SCR_LAST  = N_COL * N_ROW / 4 - 1;
  typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_LINE, CLR_SCR} state_t;
`ifdef AUTO_CLEAR_EN
  localparam state_t RST_STATE = CLR_SCR;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_n;
  logic [HW-1:0] h, h_n;
  logic [WW-1:0] w, w_n;
  logic [6:0] col, col_n;
  logic [4:0] row, row_n, row_adv;
  logic wready_n, last;
  logic [C_AXI_ADDR_WIDTH-1:0] waddr_n;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_n;
  logic [3:0] wstrb_n;
  logic [11:0] t;
  function automatic logic [C_AXI_ADDR_WIDTH-1:0] clr_addr(input logic line, input logic [4:0] r,
                                                          input logic [WW-1:0] k);
    logic [11:0] wd;
    wd = (line ? 12'(r) * 12'(N_COL / 4) : 12'd0) + 12'(k);
    return {1'b1, wd, 2'b00};
  endfunction
  assign t            = 12'(row) * 12'(N_COL) + 12'(col);
  assign row_adv      = (row == 5'(N_ROW - 1)) ? 5'd0 : row + 5'd1;
  assign last         = w == WW'(state == CLR_LINE ? LINE_LAST : SCR_LAST);
  assign char_ready_o = state == IDLE;
  assign busy_o       = state != IDLE;
  assign cursor_col_o = col;
  assign cursor_row_o = row;
  // Each beat is WR_HOLD high cycles (h = 0..WR_HOLD-1) and one low cycle (h = WR_HOLD).
  always_comb begin
    state_n  = state;
    h_n      = h;
    w_n      = w;
    col_n    = col;
    row_n    = row;
    wready_n = 1'b0;
    waddr_n  = axil_waddr_o;
    wdata_n  = axil_wdata_o;
    wstrb_n  = axil_wstrb_o;
    case (state)
      IDLE: if (char_valid_i) begin
        if (char_i >= 8'h20 && char_i <= 8'h7E) begin
          state_n  = WR_CHAR;
          h_n      = '0;
          wready_n = 1'b1;
          waddr_n  = {1'b1, 14'(t)};
          wdata_n  = {4{char_i}};
          wstrb_n  = 4'b0001 << t[1:0];
        end else if (char_i == 8'h0D) begin
          col_n = '0;
        end else if (char_i == 8'h08) begin
          col_n = (col == 7'd0) ? col : col - 7'd1;
        end else if (char_i == 8'h0A || char_i == 8'h0C) begin
          state_n  = (char_i == 8'h0A) ? CLR_LINE : CLR_SCR;
          row_n    = (char_i == 8'h0A) ? row_adv : row;
          h_n      = '0;
          w_n      = '0;
          wready_n = 1'b1;
          waddr_n  = clr_addr(char_i == 8'h0A, row_adv, '0);
          wdata_n  = 32'h2020_2020;
          wstrb_n  = 4'hF;
        end
      end
      WR_CHAR: if (h == HW'(WR_HOLD)) begin
        state_n  = CLR_LINE;
        h_n      = '0;
        w_n      = '0;
        wready_n = 1'b1;
        waddr_n  = clr_addr(1'b1, row, '0);
        wdata_n  = 32'h2020_2020;
        wstrb_n  = 4'hF;
      end else if (h == HW'(WR_HOLD - 1)) begin
        h_n     = HW'(WR_HOLD);
        col_n   = (col == 7'(N_COL - 1)) ? 7'd0 : col + 7'd1;
        row_n   = (col == 7'(N_COL - 1)) ? row_adv : row;
        state_n = (col == 7'(N_COL - 1)) ? WR_CHAR : IDLE;
      end else begin
        h_n      = h + 1'b1;
        wready_n = 1'b1;
      end
      default: if (h == HW'(WR_HOLD)) begin
        if (last) begin
          state_n = IDLE;
          col_n   = (state == CLR_SCR) ? 7'd0 : col;
          row_n   = (state == CLR_SCR) ? 5'd0 : row;
        end else begin
          w_n      = w + 1'b1;
          h_n      = '0;
          wready_n = 1'b1;
          waddr_n  = clr_addr(state == CLR_LINE, row, w + 1'b1);
          wdata_n  = 32'h2020_2020;
          wstrb_n  = 4'hF;
        end
      end else if (h == HW'(WR_HOLD - 1)) begin
        h_n = HW'(WR_HOLD);
      end else begin
        h_n      = h + 1'b1;
        wready_n = 1'b1;
      end
    endcase
  end
  // Reset parks in a gap with w = all-ones so an auto-clear starts at word 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RST_STATE;
      h             <= HW'(WR_HOLD);
      w             <= '1;
      col           <= '0;
      row           <= '0;
      axil_wready_o <= 1'b0;
      axil_waddr_o  <= '0;
      axil_wdata_o  <= '0;
      axil_wstrb_o  <= '0;
    end else begin
      state         <= state_n;
      h             <= h_n;
      w             <= w_n;
      col           <= col_n;
      row           <= row_n;
      axil_wready_o <= wready_n;
      axil_waddr_o  <= waddr_n;
      axil_wdata_o  <= wdata_n;
      axil_wstrb_o  <= wstrb_n;
    end
  end
endmodule

// File: tb/tb_vga_term_writer.sv
// tb_vga_term_writer: byte-stream stimulus against a cursor/beat-list model of the terminal writer.
module tb_vga_term_writer;
  localparam int H = 4;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [7:0] char_i = 8'h00;
  logic char_valid_i = 1'b0;
  logic char_ready_o, axil_wready_o, busy_o;
  logic [31:0] axil_wdata_o;
  logic [3:0] axil_wstrb_o;
  logic [14:0] axil_waddr_o;
  logic [6:0] cursor_col_o;
  logic [4:0] cursor_row_o;
  int n_cmp = 0, n_err = 0;
  int mcol = 0, mrow = 0, exp_busy = 0, busy = 0, bad = 0, len = 0;
  logic prev = 1'b0;
  logic [11:0] cur_at_start;
  logic [14:0] exp_addr[$], obs_addr[$];
  logic [31:0] exp_data[$], obs_data[$];
  logic [3:0]  exp_strb[$], obs_strb[$];
  int obs_len[$];

  vga_term_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .char_i(char_i), .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o), .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_waddr_o(axil_waddr_o), .axil_wready_o(axil_wready_o), .cursor_col_o(cursor_col_o),
    .cursor_row_o(cursor_row_o), .busy_o(busy_o)
  );

  always #10 clk_i = ~clk_i;

  // Beat monitor: records each beat, flags instability, cursor motion or out-of-range addresses.
  always @(negedge clk_i) begin
    if (axil_wready_o) begin
      if (!prev) begin
        obs_addr.push_back(axil_waddr_o);
        obs_data.push_back(axil_wdata_o);
        obs_strb.push_back(axil_wstrb_o);
        cur_at_start = {cursor_col_o, cursor_row_o};
        len = 1;
      end else begin
        len++;
        if (axil_waddr_o !== obs_addr[$] || axil_wdata_o !== obs_data[$] ||
            axil_wstrb_o !== obs_strb[$] || {cursor_col_o, cursor_row_o} !== cur_at_start) bad++;
      end
      if (axil_waddr_o[14] !== 1'b1 || axil_waddr_o >= 15'h4960) bad++;
    end else if (prev) obs_len.push_back(len);
    prev = axil_wready_o;
  end

  task automatic push_clear(input int wd);
    exp_addr.push_back(15'(32'h4000 + wd * 4));
    exp_data.push_back(32'h2020_2020);
    exp_strb.push_back(4'hF);
  endtask

  task automatic next_row();
    mrow = (mrow + 1) % 30;
    for (int k = 0; k < 20; k++) push_clear(mrow * 20 + k);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    exp_addr.delete(); exp_data.delete(); exp_strb.delete();
    exp_busy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      t = mrow * 80 + mcol;
      exp_addr.push_back(15'(32'h4000 + t));
      exp_data.push_back({4{b}});
      exp_strb.push_back(4'(1 << (t % 4)));
      exp_busy = H;
      if (mcol == 79) begin
        mcol = 0;
        next_row();
        exp_busy = 21 * (H + 1);
      end else mcol++;
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) begin
      next_row();
      exp_busy = 20 * (H + 1);
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      for (int k = 0; k < 600; k++) push_clear(k);
      mcol = 0;
      mrow = 0;
      exp_busy = 600 * (H + 1);
    end
  endtask

  task automatic run_byte(input logic [7:0] b);
    int n;
    model_byte(b);
    obs_addr.delete(); obs_data.delete(); obs_strb.delete(); obs_len.delete();
    bad = 0;
    n = 0;
    while (!char_ready_o && n < 5000) begin @(negedge clk_i); n++; end
    char_i = b;
    char_valid_i = 1'b1;
    @(posedge clk_i);
    #1 char_valid_i = 1'b0;
    busy = 0;
    @(negedge clk_i);
    while (!char_ready_o && busy < 5000) begin busy++; @(negedge clk_i); end
    #1;
    n_cmp++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL busy_cycles byte=%h: got %0d expected %0d", b, busy, exp_busy);
    end
    n_cmp++;
    if (obs_addr.size() != exp_addr.size() || obs_len.size() != exp_addr.size()) begin
      n_err++;
      $display("FAIL beat_count byte=%h: got %0d (%0d closed) expected %0d", b, obs_addr.size(),
               obs_len.size(), exp_addr.size());
    end else
      for (int i = 0; i < exp_addr.size(); i++) begin
        n_cmp++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] ||
            obs_strb[i] !== exp_strb[i] || obs_len[i] != H) begin
          n_err++;
          $display("FAIL beat[%0d] byte=%h: got a=%h d=%h s=%h len=%0d expected a=%h d=%h s=%h len=%0d",
                   i, b, obs_addr[i], obs_data[i], obs_strb[i], obs_len[i], exp_addr[i], exp_data[i],
                   exp_strb[i], H);
          break;
        end
      end
    n_cmp++;
    if (cursor_col_o !== 7'(mcol) || cursor_row_o !== 5'(mrow)) begin
      n_err++;
      $display("FAIL cursor byte=%h: got (%0d,%0d) expected (%0d,%0d)", b, cursor_col_o, cursor_row_o,
               mcol, mrow);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL beat_integrity byte=%h: got %0d violations expected 0", b, bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({axil_wready_o, axil_waddr_o, axil_wdata_o, axil_wstrb_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got wr=%b a=%h d=%h s=%h busy=%b expected all 0", axil_wready_o,
               axil_waddr_o, axil_wdata_o, axil_wstrb_o, busy_o);
    end
    n_cmp++;
    if (char_ready_o !== 1'b1 || cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
      n_err++;
      $display("FAIL reset_cursor: got ready=%b (%0d,%0d) expected ready=1 (0,0)", char_ready_o,
               cursor_col_o, cursor_row_o);
    end
  endtask

  task automatic test_first_char();
    run_byte(8'h41);
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 15'h4000 || obs_data[0] !== 32'h4141_4141 ||
        obs_strb[0] !== 4'h1 || busy != 4 || cursor_col_o !== 7'd1) begin
      n_err++;
      $display("FAIL first_char: got n=%0d busy=%0d col=%0d expected n=1 a=4000 busy=4 col=1",
               obs_addr.size(), busy, cursor_col_o);
    end
  endtask

  task automatic test_pos_5_2();
    run_byte(8'h0D); run_byte(8'h0A); run_byte(8'h0A);
    for (int i = 0; i < 5; i++) run_byte(8'(8'h30 + i));
    run_byte(8'h5A);
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 15'h40A5 || obs_strb[0] !== 4'h2 ||
        obs_data[0] !== 32'h5A5A_5A5A || cursor_col_o !== 7'd6 || cursor_row_o !== 5'd2) begin
      n_err++;
      $display("FAIL char_5_2: got n=%0d (%0d,%0d) expected a=40A5 s=2 cursor (6,2)", obs_addr.size(),
               cursor_col_o, cursor_row_o);
    end
  endtask

  task automatic test_wrap();
    run_byte(8'h0C);
    for (int i = 0; i < 29; i++) run_byte(8'h0A);
    for (int i = 0; i < 79; i++) run_byte(8'($urandom_range(32, 126)));
    run_byte(8'h21);
    n_cmp++;
    if (obs_addr.size() != 21 || obs_addr[0] !== 15'h495F || obs_strb[0] !== 4'h8 ||
        obs_addr[1] !== 15'h4000 || obs_addr[20] !== 15'h404C || busy != 21 * (H + 1) ||
        cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
      n_err++;
      $display("FAIL wrap_79_29: got n=%0d busy=%0d (%0d,%0d) expected n=21 busy=%0d (0,0)",
               obs_addr.size(), busy, cursor_col_o, cursor_row_o, 21 * (H + 1));
    end
  endtask

  task automatic test_ff_bs();
    run_byte(8'h43);
    run_byte(8'h0C);
    n_cmp++;
    if (obs_addr.size() != 600 || obs_addr[0] !== 15'h4000 || obs_addr[599] !== 15'h495C ||
        cursor_col_o !== 7'd0) begin
      n_err++;
      $display("FAIL form_feed: got n=%0d col=%0d expected 600 beats 4000..495C col=0", obs_addr.size(),
               cursor_col_o);
    end
    run_byte(8'h08);
    n_cmp++;
    if (obs_addr.size() != 0 || busy != 0) begin
      n_err++;
      $display("FAIL bs_col0: got n=%0d busy=%0d expected 0 0", obs_addr.size(), busy);
    end
  endtask

  task automatic test_cr_lf();
    run_byte(8'h0C);
    for (int i = 0; i < 10; i++) run_byte(8'h0A);
    for (int i = 0; i < 40; i++) run_byte(8'($urandom_range(32, 126)));
    run_byte(8'h0D);
    n_cmp++;
    if (obs_addr.size() != 0 || busy != 0 || cursor_col_o !== 7'd0 || cursor_row_o !== 5'd10) begin
      n_err++;
      $display("FAIL cr: got n=%0d (%0d,%0d) expected no beat (0,10)", obs_addr.size(), cursor_col_o,
               cursor_row_o);
    end
    for (int i = 0; i < 40; i++) run_byte(8'($urandom_range(32, 126)));
    run_byte(8'h0A);
    n_cmp++;
    if (obs_addr.size() != 20 || obs_addr[0] !== 15'h4370 || obs_addr[19] !== 15'h43BC ||
        cursor_col_o !== 7'd40 || cursor_row_o !== 5'd11) begin
      n_err++;
      $display("FAIL lf: got n=%0d (%0d,%0d) expected 20 beats 4370..43BC (40,11)", obs_addr.size(),
               cursor_col_o, cursor_row_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = 8'($urandom_range(32, 126));
      else if (r == 6) b = 8'h0D;
      else if (r == 7) b = 8'h0A;
      else if (r == 8) b = 8'h08;
      else begin
        b = 8'($urandom);
        if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0D || b == 8'h0A || b == 8'h08 || b == 8'h0C) b = 8'h7F;
      end
      run_byte(b);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 3; i++) run_byte(8'($urandom_range(32, 126)));
    obs_addr.delete(); obs_data.delete(); obs_strb.delete(); obs_len.delete();
    char_i = 8'h0C;
    char_valid_i = 1'b1;
    @(posedge clk_i);
    #1 char_valid_i = 1'b0;
    n = 0;
    while (obs_addr.size() < 100 && n < 2000) begin @(negedge clk_i); #2; n++; end
    n_cmp++;
    if (obs_addr.size() != 100 || axil_wready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reach_beat100: got %0d beats wr=%b expected 100 beats wr=1", obs_addr.size(),
               axil_wready_o);
    end
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (axil_wready_o !== 1'b0 || busy_o !== 1'b0 || char_ready_o !== 1'b1 ||
        cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
      n_err++;
      $display("FAIL reset_abort: got wr=%b busy=%b ready=%b (%0d,%0d) expected 0 0 1 (0,0)",
               axil_wready_o, busy_o, char_ready_o, cursor_col_o, cursor_row_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    mcol = 0;
    mrow = 0;
    n = obs_addr.size();
    repeat (50) @(negedge clk_i);
    n_cmp++;
    if (obs_addr.size() != n || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL no_resume: got %0d new beats busy=%b expected 0 0", obs_addr.size() - n, busy_o);
    end
    #1;
    run_byte(8'h41);
  endtask

  initial begin
    test_reset();
    test_first_char();
    test_pos_5_2();
    test_wrap();
    test_ff_bs();
    test_cr_lf();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
